// File: rtl/mailbox_pkg.sv
// Shared constants for the MMIO mailbox.
// Contents:
//   - Register offsets decoded from the low two word-address bits.
//   - Bit positions of the STATUS and CTRL registers.
//   - apply_web: builds a write word that keeps only the enabled bytes.
package mailbox_pkg;

  // Register offsets (word address bits [1:0])
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_FULL      = 2;
  localparam int ST_RX_EMPTY     = 3;
  localparam int ST_TX_OVF       = 4;
  localparam int ST_RX_UDF       = 5;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_COUNT_LSB = 16;

  // CTRL bit positions
  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_IEN_TX   = 2;
  localparam int CTRL_IEN_RX   = 3;

  // Keep the bytes whose active-low write enable is asserted; zero the rest.
  function automatic logic [31:0] apply_web(input logic [31:0] din, input logic [3:0] web);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      if (!web[b]) begin
        res[b*8 +: 8] = din[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous FIFO used for both mailbox channels.
// A push while full is accepted only when a pop happens in the same cycle.
// Otherwise the push is dropped and o_push_drop pulses.
// Flush empties the FIFO at the next edge and overrides any same-cycle push
// or pop. A push that is discarded by a flush does not raise o_push_drop.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_pop       push / pop requests (a pop while empty is ignored)
//   i_flush             discard all contents
//   i_din               push data
//   o_dout              head entry, 0 when empty
//   o_full, o_empty     occupancy flags
//   o_count             number of stored entries, 0..DEPTH
//   o_push_drop         a push was refused this cycle because the FIFO is full
module mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic          o_push_drop
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  // When full, a same-cycle pop frees the slot that the push refills.
  assign w_do_pop    = i_pop & ~o_empty & ~i_flush & ~i_rst;
  assign w_do_push   = i_push & (~o_full | w_do_pop) & ~i_flush & ~i_rst;
  assign o_push_drop = i_push & o_full & ~w_do_pop & ~i_flush & ~i_rst;

  // Storage array: written on every accepted push.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers and occupancy count. Flush and reset both empty the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_mailbox.sv
// Memory-mapped mailbox on the CPU data-memory port (SRAM-style handshake).
// A TX FIFO is written by the CPU and drained by an external agent.
// An RX FIFO is filled by an external agent and read by the CPU.
// Read data is combinational in the request cycle. Side effects commit at the
// next rising edge.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cs, i_oe, i_web, i_a, i_di CPU access (WEB active-low per byte, A word address)
//   o_do                         read data, 0 when no read is decoded
//   o_tx_data, o_tx_valid        TX head / not-empty
//   i_tx_ready                   external consumer accepts the TX head
//   i_rx_data, i_rx_valid        external producer word / offer
//   o_rx_ready                   RX FIFO can accept
//   o_irq                        level interrupt
module mmio_mailbox
  import mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_oe,
  input  logic [3:0]  i_web,
  input  logic [13:0] i_a,
  input  logic [31:0] i_di,
  output logic [31:0] o_do,
  output logic [31:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [31:0] i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_irq
);

  logic          w_wr;
  logic          w_rd;
  logic [1:0]    w_addr;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_tx_flush;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          w_rx_flush;
  logic          w_status_wr;
  logic          w_ctrl_wr;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic          w_tx_drop;
  logic [31:0]   w_rx_head;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_rx_count;
  logic          w_rx_drop;
  logic [31:0]   w_status;
  logic          w_unused;

  logic          r_tx_ovf;
  logic          r_rx_udf;
  logic          r_ien_tx;
  logic          r_ien_rx;

  // A write always wins over a read in the same access.
  assign w_addr      = i_a[1:0];
  assign w_wr        = i_cs & (i_web != 4'hF);
  assign w_rd        = i_cs & i_oe & (i_web == 4'hF);

  assign w_tx_push   = w_wr & (w_addr == REG_TXDATA);
  assign w_status_wr = w_wr & (w_addr == REG_STATUS);
  assign w_ctrl_wr   = w_wr & (w_addr == REG_CTRL);
  assign w_rx_pop    = w_rd & (w_addr == REG_RXDATA);
  assign w_tx_flush  = w_ctrl_wr & i_di[CTRL_TX_FLUSH];
  assign w_rx_flush  = w_ctrl_wr & i_di[CTRL_RX_FLUSH];

  assign o_tx_valid  = ~w_tx_empty & ~i_rst;
  assign w_tx_pop    = o_tx_valid & i_tx_ready;
  assign o_rx_ready  = ~w_rx_full & ~i_rst;
  assign w_rx_push   = i_rx_valid & o_rx_ready;

  assign o_irq = (r_ien_tx & w_tx_empty) | (r_ien_rx & ~w_rx_empty);

  // Upper address bits alias, and RX can never refuse a push because
  // o_rx_ready already excludes the full case.
  assign w_unused = ^{i_a[13:2], w_rx_drop};

  mailbox_fifo #(.DEPTH(DEPTH), .W(32)) u_tx_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_tx_push),
    .i_pop       (w_tx_pop),
    .i_flush     (w_tx_flush),
    .i_din       (apply_web(i_di, i_web)),
    .o_dout      (o_tx_data),
    .o_full      (w_tx_full),
    .o_empty     (w_tx_empty),
    .o_count     (w_tx_count),
    .o_push_drop (w_tx_drop)
  );

  mailbox_fifo #(.DEPTH(DEPTH), .W(32)) u_rx_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_rx_push),
    .i_pop       (w_rx_pop),
    .i_flush     (w_rx_flush),
    .i_din       (i_rx_data),
    .o_dout      (w_rx_head),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty),
    .o_count     (w_rx_count),
    .o_push_drop (w_rx_drop)
  );

  // Assemble the STATUS word from flags and counts.
  always_comb begin
    w_status = 32'h0000_0000;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_UDF]   = r_rx_udf;
    w_status[ST_TX_COUNT_LSB +: CW] = w_tx_count;
    w_status[ST_RX_COUNT_LSB +: CW] = w_rx_count;
  end

  // Read data mux. It is valid in the cycle of the request.
  always_comb begin
    o_do = 32'h0000_0000;
    if (w_rd) begin
      case (w_addr)
        REG_TXDATA: o_do = 32'h0000_0000;
        REG_RXDATA: o_do = w_rx_head;
        REG_STATUS: o_do = w_status;
        REG_CTRL:   o_do = {28'h000_0000, r_ien_rx, r_ien_tx, 2'b00};
        default:    o_do = 32'h0000_0000;
      endcase
    end else begin
      o_do = 32'h0000_0000;
    end
  end

  // Sticky error flags. They are set by hardware and cleared by a
  // write-one to STATUS.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      if (w_tx_drop) begin
        r_tx_ovf <= 1'b1;
      end else if (w_status_wr && i_di[ST_TX_OVF]) begin
        r_tx_ovf <= 1'b0;
      end else begin
        r_tx_ovf <= r_tx_ovf;
      end
      if (w_rx_pop && w_rx_empty) begin
        r_rx_udf <= 1'b1;
      end else if (w_status_wr && i_di[ST_RX_UDF]) begin
        r_rx_udf <= 1'b0;
      end else begin
        r_rx_udf <= r_rx_udf;
      end
    end
  end

  // Interrupt enables, loaded by any CTRL write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ien_tx <= 1'b0;
      r_ien_rx <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_ien_tx <= i_di[CTRL_IEN_TX];
      r_ien_rx <= i_di[CTRL_IEN_RX];
    end else begin
      r_ien_tx <= r_ien_tx;
      r_ien_rx <= r_ien_rx;
    end
  end

endmodule

// File: tb/tb_mmio_mailbox.sv
module tb_mmio_mailbox;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        oe;
  logic [3:0]  web;
  logic [13:0] a;
  logic [31:0] di;
  logic [31:0] dout;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queues hold FIFO contents and bits hold the flags.
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  bit m_ovf, m_udf, m_ien_tx, m_ien_rx;

  // Values sampled during the most recent step
  logic [31:0] s_do, s_tx_data;
  logic        s_tx_valid, s_rx_ready, s_irq;

  always #5 clk = ~clk;

  mmio_mailbox #(.DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cs       (cs),
    .i_oe       (oe),
    .i_web      (web),
    .i_a        (a),
    .i_di       (di),
    .o_do       (dout),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_irq      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) if (w[b] == 1'b0) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (m_tx.size() == DEPTH);
    s[1] = (m_tx.size() == 0);
    s[2] = (m_rx.size() == DEPTH);
    s[3] = (m_rx.size() == 0);
    s[4] = m_ovf;
    s[5] = m_udf;
    s[15:8]  = 8'(m_tx.size());
    s[23:16] = 8'(m_rx.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_do();
    if (!(cs && oe && web == 4'hF)) return 32'h0;
    case (a[1:0])
      2'd1:    return (m_rx.size() > 0) ? m_rx[0] : 32'h0;
      2'd2:    return exp_status();
      2'd3:    return {28'h0, m_ien_rx, m_ien_tx, 2'b00};
      default: return 32'h0;
    endcase
  endfunction

  // Apply the specified edge behaviour to the model, using the inputs held
  // through the edge.
  task automatic model_commit();
    bit wr, rd, tx_pop, rx_push;
    int tsz, rsz;
    if (rst) begin
      m_tx.delete(); m_rx.delete();
      m_ovf = 0; m_udf = 0; m_ien_tx = 0; m_ien_rx = 0;
      return;
    end
    wr  = cs && (web != 4'hF);
    rd  = cs && oe && (web == 4'hF);
    tsz = m_tx.size();
    rsz = m_rx.size();
    tx_pop  = (tsz > 0) && tx_ready;
    rx_push = rx_valid && (rsz < DEPTH);
    if (wr && a[1:0] == 2'd3 && di[0]) m_tx.delete();
    else begin
      if (tx_pop) void'(m_tx.pop_front());
      if (wr && a[1:0] == 2'd0) begin
        if (tsz < DEPTH || tx_pop) m_tx.push_back(mask_bytes(di, web));
        else m_ovf = 1;
      end
    end
    if (wr && a[1:0] == 2'd3 && di[1]) m_rx.delete();
    else begin
      if (rd && a[1:0] == 2'd1) begin
        if (rsz > 0) void'(m_rx.pop_front());
        else m_udf = 1;
      end
      if (rx_push) m_rx.push_back(rx_data);
    end
    if (wr && a[1:0] == 2'd2) begin
      if (di[4]) m_ovf = 0;
      if (di[5]) m_udf = 0;
    end
    if (wr && a[1:0] == 2'd3) begin
      m_ien_tx = di[2];
      m_ien_rx = di[3];
    end
  endtask

  // Sample and check all outputs for the current inputs, then clock one edge.
  task automatic step(input string tag);
    logic [31:0] e_txd;
    #1;
    s_do = dout; s_tx_data = tx_data; s_tx_valid = tx_valid;
    s_rx_ready = rx_ready; s_irq = irq;
    e_txd = (m_tx.size() > 0) ? m_tx[0] : 32'h0;
    chk({tag, ".do"}, s_do, exp_do());
    chk({tag, ".tx_data"}, s_tx_data, e_txd);
    chk({tag, ".tx_valid"}, {31'h0, s_tx_valid}, {31'h0, (!rst && m_tx.size() > 0)});
    chk({tag, ".rx_ready"}, {31'h0, s_rx_ready}, {31'h0, (!rst && m_rx.size() < DEPTH)});
    chk({tag, ".irq"}, {31'h0, s_irq},
        {31'h0, ((m_ien_tx && m_tx.size() == 0) || (m_ien_rx && m_rx.size() > 0))});
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; oe = 1'b0; web = 4'hF; a = 14'h0; di = 32'h0;
  endtask

  task automatic wr(input logic [1:0] ad, input logic [31:0] d, input logic [3:0] w);
    cs = 1'b1; oe = 1'b0; web = w; a = {12'h0, ad}; di = d;
  endtask

  task automatic rd(input logic [1:0] ad);
    cs = 1'b1; oe = 1'b1; web = 4'hF; a = {12'h0, ad}; di = 32'h0;
  endtask

  initial begin
    logic [1:0] ra;
    int op;
    rst = 1'b1; idle(); tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'h0;
    @(posedge clk); #1;
    m_tx.delete(); m_rx.delete();
    m_ovf = 0; m_udf = 0; m_ien_tx = 0; m_ien_rx = 0;

    // Reset state
    rd(2'd2); step("rst_status");
    chk("rst_status_const", s_do, 32'h0000_000A);
    chk("rst_rx_ready", {31'h0, s_rx_ready}, 32'h0);
    rst = 1'b0; idle(); step("rst_release");
    idle(); step("post_rst");
    chk("post_rst_rx_ready", {31'h0, s_rx_ready}, 32'h1);
    chk("post_rst_tx_valid", {31'h0, s_tx_valid}, 32'h0);

    // Three TX writes, then drain them
    wr(2'd0, 32'h11, 4'h0); step("txw1");
    wr(2'd0, 32'h22, 4'h0); step("txw2");
    wr(2'd0, 32'h33, 4'h0); step("txw3");
    rd(2'd2); step("txcnt");
    chk("tx_count3", {24'h0, s_do[15:8]}, 32'd3);
    idle(); tx_ready = 1'b1;
    step("drain1"); chk("drain_0x11", s_tx_data, 32'h11);
    step("drain2"); chk("drain_0x22", s_tx_data, 32'h22);
    step("drain3"); chk("drain_0x33", s_tx_data, 32'h33);
    step("drain4"); chk("drain_empty", {31'h0, s_tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Byte-masked write
    wr(2'd0, 32'hAABB_CCDD, 4'b1100); step("mask_wr");
    idle(); step("mask_chk");
    chk("mask_tx_data", s_tx_data, 32'h0000_CCDD);
    tx_ready = 1'b1; step("mask_drain"); tx_ready = 1'b0;

    // Overflow: DEPTH writes fill, the next one is dropped
    for (int i = 0; i < DEPTH; i++) begin
      wr(2'd0, 32'h100 + i, 4'h0); step("fill");
    end
    wr(2'd0, 32'hDEAD, 4'h0); step("ovf_wr");
    rd(2'd2); step("ovf_status");
    chk("tx_ovf_set", {31'h0, s_do[4]}, 32'h1);
    chk("tx_count_full", {24'h0, s_do[15:8]}, 32'd8);
    wr(2'd2, 32'h10, 4'h0); step("ovf_clr");
    rd(2'd2); step("ovf_status2");
    chk("tx_ovf_clr", {31'h0, s_do[4]}, 32'h0);
    wr(2'd3, 32'h1, 4'h0); step("tx_flush");

    // RX push, read, underflow
    idle(); rx_valid = 1'b1; rx_data = 32'hCAFE; step("rx_push");
    rx_valid = 1'b0; rd(2'd1); step("rx_rd");
    chk("rx_cafe", s_do, 32'h0000_CAFE);
    rd(2'd2); step("rx_st");
    chk("rx_empty_again", {31'h0, s_do[3]}, 32'h1);
    rd(2'd1); step("rx_rd_empty");
    chk("rx_rd_empty_zero", s_do, 32'h0);
    rd(2'd2); step("udf_st");
    chk("rx_udf_set", {31'h0, s_do[5]}, 32'h1);
    wr(2'd2, 32'h20, 4'h0); step("udf_clr");

    // Interrupt on RX not-empty
    wr(2'd3, 32'h8, 4'h0); step("ien_rx");
    idle(); rx_valid = 1'b1; rx_data = 32'h5A5A; step("irq_push");
    rx_valid = 1'b0; step("irq_chk");
    chk("irq_rx", {31'h0, s_irq}, 32'h1);

    // RX flush beats a same-cycle push
    wr(2'd3, 32'hA, 4'h0); rx_valid = 1'b1; rx_data = 32'h7777; step("flush_push");
    rx_valid = 1'b0; rd(2'd2); step("flush_st");
    chk("flush_rx_count", {24'h0, s_do[23:16]}, 32'd0);
    chk("flush_irq", {31'h0, s_irq}, 32'h0);
    chk("flush_flags", {30'h0, s_do[5:4]}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      op = $urandom_range(0, 9);
      ra = 2'($urandom_range(0, 3));
      idle();
      case (op)
        0: wr(2'd0, $urandom, 4'($urandom_range(0, 14)));
        1: wr(2'd0, $urandom, 4'h0);
        2: rd(2'd1);
        3: rd(2'd2);
        4: wr(2'd2, $urandom, 4'h0);
        5: wr(2'd3, ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hC), 4'h0);
        6: rd(ra);
        7: begin cs = 1'b0; oe = 1'($urandom); web = 4'($urandom); end
        8: wr(2'd1, $urandom, 4'h0);
        default: idle();
      endcase
      a[13:2] = 12'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 1) == 0);
      rx_data  = $urandom;
      rst      = ($urandom_range(0, 199) == 0);
      step("rand");
    end
    rst = 1'b0; idle(); rx_valid = 1'b0; tx_ready = 1'b0;
    step("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
